// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; head is readable combinationally.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign rdata = mem[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures ROM words into the fetch buffer and
// handles redirects, halt/resume and ROM address-window faults.
module imem_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [23:0] BASE_ADDRESS = 24'd0,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic        fetch_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         err_q, err_d;

    fetch_entry_t head;
    fetch_entry_t tail_entry;
    logic         buf_empty;
    logic         buf_full;
    logic         pc_in_window;
    logic         redir;
    logic         fault;
    logic         handshake;
    logic         enq;

    assign pc_in_window = (pc_q[31:8] == BASE_ADDRESS);
    assign redir        = redirect_valid && (state_q != BOOT);
    assign fault        = (state_q == FETCH) && !pc_in_window;
    assign handshake    = if_valid && if_ready;
    assign enq          = (state_q == FETCH) && !redirect_valid && !fault
                          && (!buf_full || handshake);
    assign tail_entry   = '{pc: pc_q, instr: rom_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redir),
        .push  (enq),
        .pop   (handshake),
        .wdata (tail_entry),
        .rdata (head),
        .empty (buf_empty),
        .full  (buf_full)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;

        // A redirect wins over both sequential advance and the window check.
        if (redir) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) err_d = 1'b1;
        end else if (enq) begin
            pc_d = pc_q + 32'(WORD_BYTES);
        end

        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (fault && !redir) begin
                    state_d = HALTED;
                    err_d   = 1'b1;
                end
            end
            HALTED: begin
                if (!halt_req && resume && pc_in_window) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign rom_addr    = pc_q;
    assign if_valid    = !buf_empty;
    assign if_pc       = buf_empty ? 32'd0 : head.pc;
    assign if_instr    = buf_empty ? 32'd0 : head.instr;
    assign if_pc_plus4 = if_pc + 32'(WORD_BYTES);
    assign halted      = (state_q == HALTED) && buf_empty;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl; inputs change and outputs are checked on the falling edge.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM stub: word i holds 0xA500_0000 + i.
    assign rom_data = 32'hA500_0000 + {2'b00, rom_addr[31:2]};

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .halted         (halted),
        .fetch_err      (fetch_err)
    );

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA500_0000 + (pc >> 2);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds reset for two cycles, then releases it; the next tick shows the BOOT->FETCH cycle.
    task automatic apply_reset(input logic ready);
        reset          = 1'b1;
        if_ready       = ready;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        reset = 1'b1;
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_fetch_err got=%b want=0", fetch_err); end
        total++; if (rom_addr !== 32'h0) begin bad++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
        total++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin bad++; $display("FAIL reset_head got pc=%h instr=%h want 0/0", if_pc, if_instr); end
        reset = 1'b0;
        $display("test_reset checked");
    endtask

    task automatic test_sequential();
        apply_reset(1'b1);
        tick();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL seq_boot_valid got=%b want=0", if_valid); end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== word_at(32'(4 * k))
                || if_pc_plus4 !== 32'(4 * k + 4)) begin
                bad++;
                $display("FAIL seq_head[%0d] got v=%b pc=%h instr=%h p4=%h want v=1 pc=%h instr=%h p4=%h",
                         k, if_valid, if_pc, if_instr, if_pc_plus4, 32'(4 * k), word_at(32'(4 * k)), 32'(4 * k + 4));
            end
            $display("seq pop pc=%h instr=%h", if_pc, if_instr);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (rom_addr !== 32'h08 || if_valid !== 1'b1 || if_pc !== 32'h00) begin
                bad++;
                $display("FAIL bp_hold[%0d] got addr=%h v=%b pc=%h want addr=08 v=1 pc=00", k, rom_addr, if_valid, if_pc);
            end
        end
        if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== word_at(32'(4 * k))) begin
                bad++;
                $display("FAIL bp_drain[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h", k, if_valid, if_pc, if_instr, 32'(4 * k));
            end
            $display("drain pop pc=%h", if_pc);
            tick();
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        tick();
        redirect_valid = 1'b0;
        total++; if (if_valid !== 1'b0 || rom_addr !== 32'h1C) begin bad++; $display("FAIL redir_flush got v=%b addr=%h want v=0 addr=1c", if_valid, rom_addr); end
        if_ready = 1'b1;
        tick();
        total++; if (if_pc !== 32'h1C || if_instr !== word_at(32'h1C) || if_valid !== 1'b1) begin bad++; $display("FAIL redir_target got v=%b pc=%h instr=%h want pc=1c instr=%h", if_valid, if_pc, if_instr, word_at(32'h1C)); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL redir_err got=%b want=0", fetch_err); end
        $display("redirect pop pc=%h instr=%h", if_pc, if_instr);
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1E;
        tick();
        redirect_valid = 1'b0;
        total++; if (fetch_err !== 1'b1 || rom_addr !== 32'h1C || if_valid !== 1'b0) begin bad++; $display("FAIL misalign_redir got err=%b addr=%h v=%b want 1/1c/0", fetch_err, rom_addr, if_valid); end
        tick();
        total++; if (if_pc !== 32'h1C || if_valid !== 1'b1) begin bad++; $display("FAIL misalign_resume got v=%b pc=%h want v=1 pc=1c", if_valid, if_pc); end
        tick();
        tick();
        total++; if (fetch_err !== 1'b1 || if_pc !== 32'h24) begin bad++; $display("FAIL misalign_sticky got err=%b pc=%h want err=1 pc=24", fetch_err, if_pc); end
        apply_reset(1'b1);
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL misalign_clear got=%b want=0", fetch_err); end
        $display("misaligned redirect checked");
    endtask

    task automatic test_window_fault();
        apply_reset(1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (if_pc !== 32'hF8) begin bad++; $display("FAIL wf_f8 got pc=%h want=f8", if_pc); end
        tick();
        total++; if (if_pc !== 32'hFC || rom_addr !== 32'h100 || fetch_err !== 1'b0) begin bad++; $display("FAIL wf_fc got pc=%h addr=%h err=%b want fc/100/0", if_pc, rom_addr, fetch_err); end
        if_ready = 1'b0;
        tick();
        total++; if (fetch_err !== 1'b1 || halted !== 1'b0 || if_pc !== 32'hFC) begin bad++; $display("FAIL wf_fault got err=%b halted=%b pc=%h want 1/0/fc", fetch_err, halted, if_pc); end
        if_ready = 1'b1;
        tick();
        total++; if (halted !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL wf_drained got halted=%b v=%b want 1/0", halted, if_valid); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        total++; if (halted !== 1'b1 || rom_addr !== 32'h100 || if_valid !== 1'b0) begin bad++; $display("FAIL wf_resume_blocked got halted=%b addr=%h v=%b want 1/100/0", halted, rom_addr, if_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b1 || rom_addr !== 32'h0) begin bad++; $display("FAIL wf_redir_halted got halted=%b addr=%h want 1/0", halted, rom_addr); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++; if (halted !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL wf_restart got halted=%b v=%b want 0/0", halted, if_valid); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || fetch_err !== 1'b1) begin bad++; $display("FAIL wf_refetch got v=%b pc=%h err=%b want 1/0/1", if_valid, if_pc, fetch_err); end
        $display("window fault checked");
    endtask

    task automatic test_halt();
        apply_reset(1'b0);
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (halted !== 1'b0 || if_pc !== 32'h0 || rom_addr !== 32'h08) begin bad++; $display("FAIL halt_entered got halted=%b pc=%h addr=%h want 0/0/08", halted, if_pc, rom_addr); end
        if_ready = 1'b1;
        tick();
        total++; if (halted !== 1'b0 || if_pc !== 32'h4 || rom_addr !== 32'h08) begin bad++; $display("FAIL halt_drain1 got halted=%b pc=%h addr=%h want 0/4/08", halted, if_pc, rom_addr); end
        tick();
        total++; if (halted !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL halt_empty got halted=%b v=%b want 1/0", halted, if_valid); end
        halt_req = 1'b1;
        resume   = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_priority got halted=%b want 1", halted); end
        tick();
        resume = 1'b0;
        total++; if (halted !== 1'b0 || rom_addr !== 32'h08) begin bad++; $display("FAIL halt_resume got halted=%b addr=%h want 0/08", halted, rom_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h08 || if_instr !== word_at(32'h08)) begin bad++; $display("FAIL halt_continue got v=%b pc=%h instr=%h want 1/08/%h", if_valid, if_pc, if_instr, word_at(32'h08)); end
        $display("halt pop pc=%h", if_pc);
    endtask

    initial begin
        reset          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_window_fault();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
